wallace_mult_sched: RTL and testbench

Issue scheduler and result tracker that shares one pipelined 16x16 radix-8 Wallace-tree multiplier among `NREQ` requesters in the systolic-array datapath.
- Arbitrates operand requests round-robin and drives the partial-product generator feeding the multiplier.
- Tags every pipeline slot and returns each 32-bit product with its requester id through a credit-protected result FIFO.
- Ensures the free-running, enable-less multiplier never loses or misattributes a result.

---
 rtl/mult_sched_pkg.sv | 15 +
 rtl/mult_rsp_fifo.sv | 62 ++++++
 rtl/wallace_mult_sched.sv | 126 ++++++++++++
 tb/tb_wallace_mult_sched.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// Shared constants and the result-FIFO entry layout for the multiplier issue scheduler.
package mult_sched_pkg;

    localparam int OP_W     = 16;
    localparam int PROD_W   = 32;
    localparam int MULT_LAT = 3;
    // Widest requester id for the supported range of 2..8 requesters
    localparam int ID_MAX_W = 3;

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [PROD_W-1:0]   product;
    } rsp_entry_t;

endpackage

// File: rtl/mult_rsp_fifo.sv
// Synchronous result FIFO; the head entry and valid flag come straight from storage registers.
module mult_rsp_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 35,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;
    logic             full;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop     = pop && (count != '0);
    assign full       = (count == CNT_W'(DEPTH));
    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // When full, a write lands on the head slot that is being popped on this same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst) !(push && full && !do_pop));

endmodule

// File: rtl/wallace_mult_sched.sv
// Round-robin issue scheduler for a shared free-running multiplier; every pipeline slot is tagged
// with its requester so results are captured into a credit-protected FIFO in issue order.
module wallace_mult_sched
    import mult_sched_pkg::*;
#(
    parameter  int NREQ       = 4,
    parameter  int LAT        = MULT_LAT,
    parameter  int FIFO_DEPTH = 4,
    localparam int ID_W       = $clog2(NREQ),
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*OP_W-1:0]   req_a,
    input  logic [NREQ*OP_W-1:0]   req_b,
    output logic [NREQ-1:0]        req_ready,
    output logic [OP_W-1:0]        mul_a,
    output logic [OP_W-1:0]        mul_b,
    input  logic [PROD_W-1:0]      mul_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [PROD_W-1:0]      rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   busy
);

    logic [ID_W-1:0]  rr_ptr;
    logic [NREQ-1:0]  grant;
    logic [ID_W-1:0]  grant_id;
    int               arb_idx;
    int               inflight;
    logic             credit_ok;
    logic             handshake;
    logic [LAT:0]     tag_valid;
    logic [ID_W-1:0]  tag_id [LAT+1];
    logic [CNT_W-1:0] fifo_count;
    logic             pop;
    rsp_entry_t       push_entry;
    rsp_entry_t       head_entry;

    // Walk from the highest offset down so the requester nearest rr_ptr wins
    always_comb begin
        grant    = '0;
        grant_id = '0;
        arb_idx  = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            arb_idx = (int'(rr_ptr) + k) % NREQ;
            if (req_valid[arb_idx]) begin
                grant          = '0;
                grant[arb_idx] = 1'b1;
                grant_id       = ID_W'(arb_idx);
            end
        end
    end

    always_comb begin
        inflight = 0;
        for (int s = 0; s <= LAT; s++) begin
            inflight = inflight + (tag_valid[s] ? 1 : 0);
        end
    end

    // Every issued operation owns a FIFO slot from issue until it is popped
    assign credit_ok = (inflight + int'(fifo_count)) < FIFO_DEPTH;
    assign req_ready = (rst && credit_ok) ? grant : '0;
    assign handshake = |(req_valid & req_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
        end else if (handshake) begin
            rr_ptr <= (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + ID_W'(1);
            mul_a  <= req_a[int'(grant_id)*OP_W +: OP_W];
            mul_b  <= req_b[int'(grant_id)*OP_W +: OP_W];
        end else begin
            mul_a  <= '0;
            mul_b  <= '0;
        end
    end

    // Tags march alongside the multiplier's internal stages; stage LAT lines up with mul_result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_valid <= '0;
            for (int s = 0; s <= LAT; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            tag_valid <= {tag_valid[LAT-1:0], handshake};
            tag_id[0] <= grant_id;
            for (int s = 1; s <= LAT; s++) begin
                tag_id[s] <= tag_id[s-1];
            end
        end
    end

    always_comb begin
        push_entry         = '0;
        push_entry.id      = ID_MAX_W'(tag_id[LAT]);
        push_entry.product = mul_result;
    end

    assign pop = rsp_valid & rsp_ready;

    mult_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(rsp_entry_t))
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (tag_valid[LAT]),
        .push_data  (push_entry),
        .pop        (pop),
        .head_data  (head_entry),
        .head_valid (rsp_valid),
        .count      (fifo_count)
    );

    assign rsp_data = head_entry.product;
    assign rsp_id   = ID_W'(head_entry.id);
    assign busy     = (|tag_valid) | rsp_valid;

endmodule

// File: tb/tb_wallace_mult_sched.sv
// Bench for wallace_mult_sched: a behavioural multiplier, a queue-based outstanding-work model
// checked every cycle, and directed scenarios with hand-computed results.
module tb_wallace_mult_sched;

    localparam int NREQ  = 4;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*16-1:0]   req_a;
    logic [NREQ*16-1:0]   req_b;
    logic [NREQ-1:0]      req_ready;
    logic [15:0]          mul_a;
    logic [15:0]          mul_b;
    logic [31:0]          mul_result;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_data;
    logic [1:0]           rsp_id;
    logic                 busy;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int          id;
        logic [31:0] prod;
        int          due;
    } exp_t;

    exp_t expq[$];
    int   grant_log[$];
    int   rr_m = 0;
    int   now = 0;
    logic [31:0] mpipe [LAT];

    wallace_mult_sched #(
        .NREQ       (NREQ),
        .LAT        (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Free-running multiplier: operands seen after edge E0 appear on mul_result after E3
    always @(posedge clk) begin
        mpipe[0] <= 32'(mul_a) * 32'(mul_b);
        for (int i = 1; i < LAT; i++) begin
            mpipe[i] <= mpipe[i-1];
        end
    end
    assign mul_result = mpipe[LAT-1];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: every accepted request is outstanding until popped; credit is the outstanding count
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_ready;
        logic            exp_valid;
        int              g;
        exp_t            e;
        now++;
        if (!rst) begin
            checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
            checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            checkOutput("rst_busy", 64'(busy), 64'd0);
            expq.delete();
            rr_m = 0;
        end else begin
            exp_ready = '0;
            g = -1;
            if (expq.size() < DEPTH) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && req_valid[(rr_m + k) % NREQ]) begin
                        g = (rr_m + k) % NREQ;
                    end
                end
            end
            if (g >= 0) begin
                exp_ready[g] = 1'b1;
            end
            exp_valid = (expq.size() > 0) && (expq[0].due <= now);
            checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
            checkOutput("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
            checkOutput("busy", 64'(busy), 64'(expq.size() != 0));
            if (exp_valid) begin
                checkOutput("rsp_data", 64'(rsp_data), 64'(expq[0].prod));
                checkOutput("rsp_id", 64'(rsp_id), 64'(expq[0].id));
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    grant_log.push_back(i);
                end
            end
            if (exp_valid && rsp_ready) begin
                void'(expq.pop_front());
            end
            if (g >= 0) begin
                e.id   = g;
                e.prod = 32'(req_a[g*16 +: 16]) * 32'(req_b[g*16 +: 16]);
                e.due  = now + LAT + 2;
                expq.push_back(e);
                rr_m = (g + 1) % NREQ;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic rdy, input int cycles);
        req_valid = valid;
        rsp_ready = rdy;
        repeat (cycles) tick();
    endtask

    task automatic setOperands(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[i*16 +: 16] = a;
        req_b[i*16 +: 16] = b;
    endtask

    task automatic waitRsp(output int n);
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int fair_exp [5];
        fair_exp = '{2, 3, 0, 1, 2};
        rst       = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        #1;
        checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_mul_a", 64'(mul_a), 64'd0);
        applyStimulus('0, 1'b0, 2);
        rst = 1'b1;
        tick();

        $display("[TB] single request");
        setOperands(0, 16'd3, 16'd5);
        applyStimulus(4'b0001, 1'b0, 1);
        req_valid = '0;
        waitRsp(n);
        checkOutput("single_latency", 64'(n), 64'd4);
        checkOutput("single_data", 64'(rsp_data), 64'd15);
        checkOutput("single_id", 64'(rsp_id), 64'd0);
        applyStimulus('0, 1'b1, 1);
        rsp_ready = 1'b0;
        checkOutput("single_busy_after_pop", 64'(busy), 64'd0);

        $display("[TB] full range");
        setOperands(0, 16'hFFFF, 16'hFFFF);
        setOperands(1, 16'h1234, 16'h0000);
        applyStimulus(4'b0001, 1'b0, 1);
        applyStimulus(4'b0010, 1'b0, 1);
        req_valid = '0;
        waitRsp(n);
        checkOutput("max_data", 64'(rsp_data), 64'hFFFE0001);
        checkOutput("max_id", 64'(rsp_id), 64'd0);
        applyStimulus('0, 1'b1, 1);
        checkOutput("zero_valid", 64'(rsp_valid), 64'd1);
        checkOutput("zero_data", 64'(rsp_data), 64'd0);
        checkOutput("zero_id", 64'(rsp_id), 64'd1);
        applyStimulus('0, 1'b1, 1);
        rsp_ready = 1'b0;

        $display("[TB] fairness");
        for (int i = 0; i < NREQ; i++) begin
            setOperands(i, 16'(100 + i), 16'(1000 * (i + 1)));
        end
        grant_log.delete();
        applyStimulus('1, 1'b1, 12);
        applyStimulus('0, 1'b1, 8);
        checkOutput("fair_grants_ge5", 64'(grant_log.size() >= 5), 64'd1);
        for (int j = 0; j < 5; j++) begin
            checkOutput($sformatf("fair_grant%0d", j),
                        64'(j < grant_log.size() ? grant_log[j] : -1), 64'(fair_exp[j]));
        end

        $display("[TB] backpressure");
        grant_log.delete();
        applyStimulus('1, 1'b0, 8);
        checkOutput("bp_handshakes", 64'(grant_log.size()), 64'd4);
        checkOutput("bp_ready_zero", 64'(req_ready), 64'd0);
        grant_log.delete();
        applyStimulus('1, 1'b1, 6);
        checkOutput("bp_resumed", 64'(grant_log.size() > 0), 64'd1);
        applyStimulus('0, 1'b1, 10);

        $display("[TB] simultaneous push and pop");
        grant_log.delete();
        applyStimulus('1, 1'b0, 7);
        checkOutput("simul_count_before", 64'(dut.fifo_count), 64'd3);
        applyStimulus('1, 1'b1, 1);
        checkOutput("simul_count_after", 64'(dut.fifo_count), 64'd3);
        applyStimulus('1, 1'b0, 4);
        checkOutput("simul_handshakes", 64'(grant_log.size()), 64'd5);
        applyStimulus('0, 1'b1, 12);

        $display("[TB] reset mid-operation");
        applyStimulus('1, 1'b0, 5);
        checkOutput("pre_rst_count", 64'(dut.fifo_count), 64'd1);
        rst = 1'b0;
        #1;
        checkOutput("midrst_req_ready", 64'(req_ready), 64'd0);
        checkOutput("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_mul_b", 64'(mul_b), 64'd0);
        applyStimulus('0, 1'b0, 2);
        rst = 1'b1;
        applyStimulus('0, 1'b1, 8);
        checkOutput("post_rst_no_stale", 64'(rsp_valid), 64'd0);
        rsp_ready = 1'b0;
        setOperands(2, 16'd7, 16'd9);
        applyStimulus(4'b0100, 1'b0, 1);
        req_valid = '0;
        waitRsp(n);
        checkOutput("post_rst_latency", 64'(n), 64'd4);
        checkOutput("post_rst_data", 64'(rsp_data), 64'd63);
        checkOutput("post_rst_id", 64'(rsp_id), 64'd2);
        applyStimulus('0, 1'b1, 2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
